axi_frame_ram: RTL and testbench

AXI_FRAME_RAM -- requirements
Module: axi_frame_ram

---
 rtl/axi_frame_ram_pkg.sv | 27 ++
 rtl/axi_frame_ram_mem.sv | 43 ++++
 rtl/axi_frame_ram.sv | 243 ++++++++++++++++++++++++
 tb/tb_axi_frame_ram.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_frame_ram_pkg.sv
// Shared definitions for the AXI4 frame RAM: FSM state encodings,
// AXI response codes and the byte-address to word-offset helper.
package axi_frame_ram_pkg;

    // Write channel FSM states
    localparam logic [1:0] W_IDLE  = 2'd0;
    localparam logic [1:0] W_DATA  = 2'd1;
    localparam logic [1:0] W_RESP  = 2'd2;

    // Read channel FSM states
    localparam logic [1:0] R_IDLE  = 2'd0;
    localparam logic [1:0] R_FETCH = 2'd1;
    localparam logic [1:0] R_DATA  = 2'd2;

    // AXI response codes
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Word offset of a byte address relative to the window base.
    function automatic logic [29:0] word_offset(input logic [31:0] addr,
                                                input logic [31:0] base);
        logic [31:0] diff;
        diff = addr - base;
        return diff[31:2];
    endfunction

endpackage

// File: rtl/axi_frame_ram_mem.sv
// Simple dual-port synchronous RAM: one byte-enabled write port and one
// registered read port. A read and a write to the same word in the same
// cycle returns the previous contents. Only the read register is reset;
// the array itself keeps its contents across reset.
module axi_frame_ram_mem #(
    parameter int WORDS = 2048,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [3:0]    wstrb,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    input  logic          rd_zero,
    output logic [31:0]   rdata
);

    logic [31:0] ram [0:WORDS-1];

    // Byte-enabled write into the array
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) begin
                    ram[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    // Registered read; rd_zero substitutes zero data for rejected bursts
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= 32'h0000_0000;
        end else if (re) begin
            rdata <= rd_zero ? 32'h0000_0000 : ram[raddr];
        end
    end

endmodule

// File: rtl/axi_frame_ram.sv
// AXI4 slave frame RAM. Every burst is treated as INCR with 4-byte beats;
// wlast, size and burst type are not used. Read and write channels run
// independent FSMs sharing one dual-port RAM; the word index wraps modulo
// MEM_WORDS.
// Optional build macro AXI_RAM_ERR_RESP_EN: bursts starting below BASE_ADDR
// or running past the last word are answered with SLVERR, their writes are
// dropped and their reads return zero.
module axi_frame_ram
    import axi_frame_ram_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int          MEM_WORDS = 2048,
    parameter int          ID_WIDTH  = 1
) (
    input  logic                s_axi_aclk,
    input  logic                s_axi_areset,
    input  logic [ID_WIDTH-1:0] s_axi_awid,
    input  logic [31:0]         s_axi_awaddr,
    input  logic [7:0]          s_axi_awlen,
    input  logic                s_axi_awvalid,
    output logic                s_axi_awready,
    input  logic [31:0]         s_axi_wdata,
    input  logic [3:0]          s_axi_wstrb,
    input  logic                s_axi_wvalid,
    output logic                s_axi_wready,
    output logic [ID_WIDTH-1:0] s_axi_bid,
    output logic [1:0]          s_axi_bresp,
    output logic                s_axi_bvalid,
    input  logic                s_axi_bready,
    input  logic [ID_WIDTH-1:0] s_axi_arid,
    input  logic [31:0]         s_axi_araddr,
    input  logic [7:0]          s_axi_arlen,
    input  logic                s_axi_arvalid,
    output logic                s_axi_arready,
    output logic [ID_WIDTH-1:0] s_axi_rid,
    output logic [31:0]         s_axi_rdata,
    output logic [1:0]          s_axi_rresp,
    output logic                s_axi_rlast,
    output logic                s_axi_rvalid,
    input  logic                s_axi_rready
);

    localparam int IDX_W = $clog2(MEM_WORDS);

    logic [1:0]       w_state;
    logic [IDX_W-1:0] w_idx;
    logic [7:0]       w_len;
    logic [7:0]       w_cnt;
    logic [1:0]       r_state;
    logic [IDX_W-1:0] r_idx;
    logic [7:0]       r_len;
    logic [7:0]       r_cnt;

    logic [IDX_W-1:0] aw_idx;
    logic [IDX_W-1:0] ar_idx;
    logic             aw_hs;
    logic             w_hs;
    logic             ar_hs;
    logic             mem_we;
    logic             mem_re;
    logic             rd_zero;
    logic [1:0]       w_resp_code;
    logic [1:0]       r_resp_code;

    assign aw_idx = IDX_W'(word_offset(s_axi_awaddr, BASE_ADDR));
    assign ar_idx = IDX_W'(word_offset(s_axi_araddr, BASE_ADDR));
    assign aw_hs  = s_axi_awready && s_axi_awvalid;
    assign w_hs   = s_axi_wready && s_axi_wvalid;
    assign ar_hs  = s_axi_arready && s_axi_arvalid;
    assign mem_re = (r_state == R_FETCH);

`ifdef AXI_RAM_ERR_RESP_EN
    logic [29:0] aw_off;
    logic [29:0] ar_off;
    logic [30:0] aw_end;
    logic [30:0] ar_end;
    logic        aw_bad;
    logic        ar_bad;
    logic        w_err;
    logic        r_err;

    assign aw_off = word_offset(s_axi_awaddr, BASE_ADDR);
    assign ar_off = word_offset(s_axi_araddr, BASE_ADDR);
    assign aw_end = {1'b0, aw_off} + {23'd0, s_axi_awlen};
    assign ar_end = {1'b0, ar_off} + {23'd0, s_axi_arlen};
    assign aw_bad = (s_axi_awaddr < BASE_ADDR) || (aw_end >= 31'(MEM_WORDS));
    assign ar_bad = (s_axi_araddr < BASE_ADDR) || (ar_end >= 31'(MEM_WORDS));

    // Capture the range verdict of each burst at its address handshake
    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            w_err <= 1'b0;
            r_err <= 1'b0;
        end else begin
            if (aw_hs) begin
                w_err <= aw_bad;
            end
            if (ar_hs) begin
                r_err <= ar_bad;
            end
        end
    end

    assign w_resp_code = w_err ? RESP_SLVERR : RESP_OKAY;
    assign r_resp_code = r_err ? RESP_SLVERR : RESP_OKAY;
    assign mem_we      = w_hs && !w_err;
    assign rd_zero     = r_err;
`else
    assign w_resp_code = RESP_OKAY;
    assign r_resp_code = RESP_OKAY;
    assign mem_we      = w_hs;
    assign rd_zero     = 1'b0;
`endif

    // Write channel FSM: accept one burst, take its beats, return one response
    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            w_state       <= W_IDLE;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= RESP_OKAY;
            s_axi_bid     <= '0;
            w_idx         <= '0;
            w_len         <= 8'd0;
            w_cnt         <= 8'd0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (aw_hs) begin
                        s_axi_bid     <= s_axi_awid;
                        w_idx         <= aw_idx;
                        w_len         <= s_axi_awlen;
                        w_cnt         <= 8'd0;
                        s_axi_awready <= 1'b0;
                        s_axi_wready  <= 1'b1;
                        w_state       <= W_DATA;
                    end else begin
                        s_axi_awready <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (w_hs) begin
                        w_idx <= w_idx + IDX_W'(1);
                        w_cnt <= w_cnt + 8'd1;
                        if (w_cnt == w_len) begin
                            s_axi_wready <= 1'b0;
                            s_axi_bvalid <= 1'b1;
                            s_axi_bresp  <= w_resp_code;
                            w_state      <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        s_axi_bvalid  <= 1'b0;
                        s_axi_awready <= 1'b1;
                        w_state       <= W_IDLE;
                    end
                end
                default: begin
                    s_axi_awready <= 1'b0;
                    s_axi_wready  <= 1'b0;
                    s_axi_bvalid  <= 1'b0;
                    w_state       <= W_IDLE;
                end
            endcase
        end
    end

    // Read channel FSM: fetch one word per beat, present it until accepted
    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            r_state       <= R_IDLE;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rlast   <= 1'b0;
            s_axi_rresp   <= RESP_OKAY;
            s_axi_rid     <= '0;
            r_idx         <= '0;
            r_len         <= 8'd0;
            r_cnt         <= 8'd0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        s_axi_rid     <= s_axi_arid;
                        r_idx         <= ar_idx;
                        r_len         <= s_axi_arlen;
                        r_cnt         <= 8'd0;
                        s_axi_arready <= 1'b0;
                        r_state       <= R_FETCH;
                    end else begin
                        s_axi_arready <= 1'b1;
                    end
                end
                R_FETCH: begin
                    s_axi_rvalid <= 1'b1;
                    s_axi_rlast  <= (r_cnt == r_len);
                    s_axi_rresp  <= r_resp_code;
                    r_state      <= R_DATA;
                end
                R_DATA: begin
                    if (s_axi_rready) begin
                        s_axi_rvalid <= 1'b0;
                        s_axi_rlast  <= 1'b0;
                        if (r_cnt == r_len) begin
                            s_axi_arready <= 1'b1;
                            r_state       <= R_IDLE;
                        end else begin
                            r_cnt   <= r_cnt + 8'd1;
                            r_idx   <= r_idx + IDX_W'(1);
                            r_state <= R_FETCH;
                        end
                    end
                end
                default: begin
                    s_axi_arready <= 1'b0;
                    s_axi_rvalid  <= 1'b0;
                    s_axi_rlast   <= 1'b0;
                    r_state       <= R_IDLE;
                end
            endcase
        end
    end

    axi_frame_ram_mem #(
        .WORDS (MEM_WORDS),
        .AW    (IDX_W)
    ) u_mem (
        .clk     (s_axi_aclk),
        .rst     (s_axi_areset),
        .we      (mem_we),
        .waddr   (w_idx),
        .wdata   (s_axi_wdata),
        .wstrb   (s_axi_wstrb),
        .re      (mem_re),
        .raddr   (r_idx),
        .rd_zero (rd_zero),
        .rdata   (s_axi_rdata)
    );

endmodule

// File: tb/tb_axi_frame_ram.sv
// Self-checking bench for axi_frame_ram: a word-array reference model is
// updated from each write burst and compared against every read beat.
// Honours AXI_RAM_ERR_RESP_EN when the build defines it.
`timescale 1ns/1ps
module tb_axi_frame_ram;

    localparam logic [31:0] BASE  = 32'h4000_0000;
    localparam int          WORDS = 2048;
    localparam int          IDW   = 2;
`ifdef AXI_RAM_ERR_RESP_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic           s_axi_aclk = 1'b0;
    logic           s_axi_areset;
    logic [IDW-1:0] s_axi_awid;
    logic [31:0]    s_axi_awaddr;
    logic [7:0]     s_axi_awlen;
    logic           s_axi_awvalid;
    logic           s_axi_awready;
    logic [31:0]    s_axi_wdata;
    logic [3:0]     s_axi_wstrb;
    logic           s_axi_wvalid;
    logic           s_axi_wready;
    logic [IDW-1:0] s_axi_bid;
    logic [1:0]     s_axi_bresp;
    logic           s_axi_bvalid;
    logic           s_axi_bready;
    logic [IDW-1:0] s_axi_arid;
    logic [31:0]    s_axi_araddr;
    logic [7:0]     s_axi_arlen;
    logic           s_axi_arvalid;
    logic           s_axi_arready;
    logic [IDW-1:0] s_axi_rid;
    logic [31:0]    s_axi_rdata;
    logic [1:0]     s_axi_rresp;
    logic           s_axi_rlast;
    logic           s_axi_rvalid;
    logic           s_axi_rready;

    axi_frame_ram #(
        .BASE_ADDR (BASE),
        .MEM_WORDS (WORDS),
        .ID_WIDTH  (IDW)
    ) dut (
        .s_axi_aclk    (s_axi_aclk),
        .s_axi_areset  (s_axi_areset),
        .s_axi_awid    (s_axi_awid),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awlen   (s_axi_awlen),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bid     (s_axi_bid),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_arid    (s_axi_arid),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arlen   (s_axi_arlen),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rid     (s_axi_rid),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rlast   (s_axi_rlast),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready)
    );

    always #5 s_axi_aclk = ~s_axi_aclk;

    logic [31:0] model [0:WORDS-1];
    logic [31:0] wbuf  [0:255];
    logic [3:0]  sbuf  [0:255];
    logic [31:0] last_rdata;
    int          errors = 0;
    int          checks = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge s_axi_aclk);
        #1;
    endtask

    function automatic int widx(input logic [31:0] addr);
        logic [31:0] d;
        d = (addr - BASE) >> 2;
        return int'(d % 32'(WORDS));
    endfunction

    function automatic bit is_bad(input logic [31:0] addr, input int len);
        longint off;
        if (!ERR_EN) return 1'b0;
        if (addr < BASE) return 1'b1;
        off = longint'((addr - BASE) >> 2);
        return (off + longint'(len)) >= longint'(WORDS);
    endfunction

    // Write burst from wbuf/sbuf; updates the model and checks the response.
    task automatic axi_write(input logic [31:0] addr, input int len, input logic [IDW-1:0] id,
                             input bit gaps, input string tag);
        int t;
        int idx;
        bit bad;
        bad = is_bad(addr, len);
        idx = widx(addr);
        s_axi_awaddr  = addr;
        s_axi_awlen   = 8'(len);
        s_axi_awid    = id;
        s_axi_awvalid = 1'b1;
        t = 0;
        while (!s_axi_awready && t < 200) begin tick(); t++; end
        if (!s_axi_awready) check_val({tag, " awready"}, 32'(s_axi_awready), 32'd1);
        tick();
        s_axi_awvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                s_axi_wvalid = 1'b0;
                tick();
            end
            s_axi_wdata  = wbuf[i];
            s_axi_wstrb  = sbuf[i];
            s_axi_wvalid = 1'b1;
            t = 0;
            while (!s_axi_wready && t < 200) begin tick(); t++; end
            if (!s_axi_wready) check_val({tag, " wready"}, 32'(s_axi_wready), 32'd1);
            tick();
            if (!bad) begin
                for (int b = 0; b < 4; b++) begin
                    if (sbuf[i][b]) model[(idx + i) % WORDS][b*8 +: 8] = wbuf[i][b*8 +: 8];
                end
            end
        end
        s_axi_wvalid = 1'b0;
        check_val({tag, " bvalid_rise"}, 32'(s_axi_bvalid), 32'd1);
        repeat ($urandom_range(0, 3)) tick();
        check_val({tag, " bvalid_hold"}, 32'(s_axi_bvalid), 32'd1);
        check_val({tag, " bid"}, 32'(s_axi_bid), 32'(id));
        check_val({tag, " bresp"}, 32'(s_axi_bresp), bad ? 32'd2 : 32'd0);
        s_axi_bready = 1'b1;
        tick();
        s_axi_bready = 1'b0;
        check_val({tag, " bvalid_drop"}, 32'(s_axi_bvalid), 32'd0);
    endtask

    // Read burst; every beat is compared with the model. Optional stall.
    task automatic axi_read(input logic [31:0] addr, input int len, input logic [IDW-1:0] id,
                            input int stall_beat, input int stall_cyc, input string tag);
        int t;
        int idx;
        bit bad;
        logic [31:0] exp;
        bad = is_bad(addr, len);
        idx = widx(addr);
        s_axi_araddr  = addr;
        s_axi_arlen   = 8'(len);
        s_axi_arid    = id;
        s_axi_arvalid = 1'b1;
        t = 0;
        while (!s_axi_arready && t < 200) begin tick(); t++; end
        if (!s_axi_arready) check_val({tag, " arready"}, 32'(s_axi_arready), 32'd1);
        tick();
        s_axi_arvalid = 1'b0;
        check_val({tag, " fetch_rvalid"}, 32'(s_axi_rvalid), 32'd0);
        tick();
        check_val({tag, " first_rvalid"}, 32'(s_axi_rvalid), 32'd1);
        for (int i = 0; i <= len; i++) begin
            t = 0;
            while (!s_axi_rvalid && t < 50) begin tick(); t++; end
            exp = bad ? 32'h0 : model[(idx + i) % WORDS];
            check_val({tag, " rdata"}, s_axi_rdata, exp);
            check_val({tag, " rlast"}, 32'(s_axi_rlast), (i == len) ? 32'd1 : 32'd0);
            check_val({tag, " rresp"}, 32'(s_axi_rresp), bad ? 32'd2 : 32'd0);
            check_val({tag, " rid"}, 32'(s_axi_rid), 32'(id));
            if (i == stall_beat) begin
                repeat (stall_cyc) begin
                    tick();
                    check_val({tag, " stall_rvalid"}, 32'(s_axi_rvalid), 32'd1);
                    check_val({tag, " stall_rdata"}, s_axi_rdata, exp);
                end
            end
            last_rdata   = s_axi_rdata;
            s_axi_rready = 1'b1;
            tick();
            s_axi_rready = 1'b0;
        end
    endtask

    // Bounded run time: stop with a failure if the sequence stalls
    initial begin
        #800000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;
        s_axi_areset  = 1'b1;
        s_axi_awid    = '0;
        s_axi_awaddr  = 32'h0;
        s_axi_awlen   = 8'd0;
        s_axi_awvalid = 1'b0;
        s_axi_wdata   = 32'h0;
        s_axi_wstrb   = 4'h0;
        s_axi_wvalid  = 1'b0;
        s_axi_bready  = 1'b0;
        s_axi_arid    = '0;
        s_axi_araddr  = 32'h0;
        s_axi_arlen   = 8'd0;
        s_axi_arvalid = 1'b0;
        s_axi_rready  = 1'b0;
        last_rdata    = 32'h0;

        // Reset state
        repeat (3) tick();
        check_val("rst awready", 32'(s_axi_awready), 32'd0);
        check_val("rst arready", 32'(s_axi_arready), 32'd0);
        check_val("rst wready",  32'(s_axi_wready),  32'd0);
        check_val("rst bvalid",  32'(s_axi_bvalid),  32'd0);
        check_val("rst rvalid",  32'(s_axi_rvalid),  32'd0);
        check_val("rst rlast",   32'(s_axi_rlast),   32'd0);
        check_val("rst rdata",   s_axi_rdata,        32'd0);
        check_val("rst bid",     32'(s_axi_bid),     32'd0);
        s_axi_areset = 1'b0;
        check_val("rel arready_now", 32'(s_axi_arready), 32'd0);
        tick();
        check_val("rel awready", 32'(s_axi_awready), 32'd1);
        check_val("rel arready", 32'(s_axi_arready), 32'd1);

        // Fill the whole RAM with maximum-length bursts
        for (int k = 0; k < WORDS / 256; k++) begin
            for (int i = 0; i < 256; i++) begin
                wbuf[i] = $urandom;
                sbuf[i] = 4'hF;
            end
            axi_write(BASE + 32'(k * 1024), 255, 2'(k), 1'b0, "fill");
        end
        axi_read(BASE + 32'd1020, 255, 2'd3, -1, 0, "fill_rd");

        // Sixteen-beat burst of 0..15 at the base address
        for (int i = 0; i < 16; i++) begin
            wbuf[i] = 32'(i);
            sbuf[i] = 4'hF;
        end
        axi_write(BASE, 15, 2'd1, 1'b0, "seq_wr");
        axi_read(BASE, 15, 2'd2, -1, 0, "seq_rd");
        axi_read(BASE, 15, 2'd1, 5, 3, "stall_rd");

        // Partial-strobe overwrite
        wbuf[0] = 32'h1122_3344;
        sbuf[0] = 4'hF;
        axi_write(BASE + 32'd400, 0, 2'd0, 1'b0, "strb_full");
        wbuf[0] = 32'hAABB_CCDD;
        sbuf[0] = 4'b0011;
        axi_write(BASE + 32'd400, 0, 2'd3, 1'b0, "strb_part");
        axi_read(BASE + 32'd400, 0, 2'd0, -1, 0, "strb_rd");
        check_val("strb_merge", last_rdata, 32'h1122_CCDD);

        // One past the end: rejected with the error option, else wraps to word 0
        wbuf[0] = 32'hDEAD_BEEF;
        sbuf[0] = 4'hF;
        axi_write(BASE + 32'(WORDS * 4), 0, 2'd2, 1'b0, "past_end_wr");
        axi_read(BASE, 0, 2'd1, -1, 0, "word0_rd");
        axi_read(BASE + 32'(WORDS * 4), 1, 2'd2, -1, 0, "past_end_rd");
        axi_read(BASE - 32'd4, 0, 2'd3, -1, 0, "below_base_rd");
        axi_read(BASE + 32'((WORDS - 2) * 4), 1, 2'd0, -1, 0, "last_words_rd");

        // Randomised in-range traffic
        for (int n = 0; n < 40; n++) begin
            int len;
            int idx;
            len = $urandom_range(0, 15);
            idx = $urandom_range(0, WORDS - 1 - len);
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i <= len; i++) begin
                    wbuf[i] = $urandom;
                    sbuf[i] = 4'($urandom);
                end
                axi_write(BASE + 32'(idx * 4), len, 2'($urandom), 1'b1, "rnd_wr");
            end else begin
                axi_read(BASE + 32'(idx * 4), len, 2'($urandom), $urandom_range(0, len),
                         $urandom_range(0, 3), "rnd_rd");
            end
        end

        // Concurrent write and read on disjoint regions
        for (int i = 0; i < 8; i++) begin
            wbuf[i] = $urandom;
            sbuf[i] = 4'hF;
        end
        fork
            axi_write(BASE + 32'd2000, 7, 2'd1, 1'b1, "conc_wr");
            axi_read(BASE + 32'd4000, 7, 2'd2, 2, 2, "conc_rd");
        join
        axi_read(BASE + 32'd2000, 7, 2'd3, -1, 0, "conc_chk");

        // Reset in the middle of a read burst
        s_axi_araddr  = BASE;
        s_axi_arlen   = 8'd15;
        s_axi_arid    = 2'd1;
        s_axi_arvalid = 1'b1;
        t = 0;
        while (!s_axi_arready && t < 200) begin tick(); t++; end
        tick();
        s_axi_arvalid = 1'b0;
        s_axi_rready  = 1'b1;
        repeat (5) tick();
        s_axi_rready = 1'b0;
        t = 0;
        while (!s_axi_rvalid && t < 20) begin tick(); t++; end
        check_val("mid rvalid", 32'(s_axi_rvalid), 32'd1);
        s_axi_areset = 1'b1;
        #1;
        check_val("mid_rst rvalid",  32'(s_axi_rvalid),  32'd0);
        check_val("mid_rst rdata",   s_axi_rdata,        32'd0);
        check_val("mid_rst rid",     32'(s_axi_rid),     32'd0);
        check_val("mid_rst arready", 32'(s_axi_arready), 32'd0);
        tick();
        tick();
        s_axi_areset = 1'b0;
        check_val("rel2 arready_now", 32'(s_axi_arready), 32'd0);
        tick();
        check_val("rel2 arready", 32'(s_axi_arready), 32'd1);
        axi_read(BASE, 15, 2'd2, 9, 1, "post_rst_rd");
        for (int i = 0; i < 4; i++) begin
            wbuf[i] = $urandom;
            sbuf[i] = 4'hF;
        end
        axi_write(BASE + 32'd800, 3, 2'd3, 1'b0, "post_rst_wr");
        axi_read(BASE + 32'd800, 3, 2'd0, -1, 0, "post_rst_chk");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
